hand_buffer: RTL and testbench



---
 rtl/hand_buffer.sv | 161 ++++++++++++++++
 tb/tb_hand_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hand_buffer.sv
// Per-player hand storage: requests draws from the deck, captures the delivered cards,
// and removes played cards by moving the last card into the vacated slot.
module hand_buffer #(
    parameter int MAX_CARDS = 32,
    parameter int IDX_W     = 5,
    parameter int TIMEOUT   = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [2:0]       i_req_draw,
    input  logic             i_play,
    input  logic [IDX_W-1:0] i_play_idx,
    input  logic [IDX_W-1:0] i_sel_idx,
    input  logic             i_deck_done,
    input  logic             i_drawn,
    input  logic [5:0]       i_card,
    output logic [2:0]       o_draw,
    output logic [5:0]       o_sel_card,
    output logic [IDX_W:0]   o_count,
    output logic             o_busy,
    output logic [5:0]       o_played_card,
    output logic             o_played_valid,
    output logic             o_err,
    output logic             o_overflow
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       need_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [IDX_W:0]   count_reg;
    logic [5:0]       hand_reg  [MAX_CARDS];
    logic [5:0]       hand_next [MAX_CARDS];
    logic [5:0]       played_card_reg;
    logic             played_valid_reg;
    logic             err_reg;
    logic             overflow_reg;

    logic             play_ok;
    logic             play_bad;
    logic             full;
    logic             capture;
    logic             recv_done;
    logic             timer_expire;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [5:0]       last_card;
    logic [2:0]       draw_code;

    assign play_ok      = (state_reg == S_IDLE) && i_play && ({1'b0, i_play_idx} < count_reg);
    assign play_bad     = (state_reg == S_IDLE) && i_play && !({1'b0, i_play_idx} < count_reg);
    assign full         = (count_reg == (IDX_W+1)'(MAX_CARDS));
    assign capture      = (state_reg == S_RECV) && i_drawn && !full;
    assign recv_done    = (state_reg == S_RECV) && i_drawn && (need_reg == 3'd1);
    assign timer_expire = (state_reg == S_RECV) && !i_drawn && (timer_reg == TMR_W'(TIMEOUT - 1));
    assign last_idx     = IDX_W'(count_reg - 1'b1);
    assign wr_idx       = count_reg[IDX_W-1:0];
    assign last_card    = hand_reg[last_idx];

    // A played slot is refilled with the last card so the hand stays dense.
    generate
        for (genvar gi = 0; gi < MAX_CARDS; gi++) begin : g_slot
            assign hand_next[gi] = (play_ok && (i_play_idx == IDX_W'(gi))) ? last_card :
                                   (capture && (wr_idx == IDX_W'(gi)))     ? i_card    :
                                                                             hand_reg[gi];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_CARDS; i++) begin
                hand_reg[i] <= '0;
            end
        end else begin
            hand_reg <= hand_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (!i_play && (i_req_draw != 3'b000)) state_next = S_REQ;
            S_REQ:   if (i_deck_done) state_next = S_RECV;
            S_RECV:  if (recv_done || timer_expire) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (need_reg)
            3'd4:    draw_code = 3'b100;
            3'd2:    draw_code = 3'b010;
            default: draw_code = 3'b001;
        endcase
        o_busy = (state_reg != S_IDLE);
        o_draw = ((state_reg == S_REQ) && i_deck_done) ? draw_code : 3'b000;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            need_reg         <= '0;
            timer_reg        <= '0;
            count_reg        <= '0;
            played_card_reg  <= '0;
            played_valid_reg <= 1'b0;
            err_reg          <= 1'b0;
            overflow_reg     <= 1'b0;
        end else begin
            played_valid_reg <= play_ok;
            err_reg          <= play_bad || timer_expire;
            if (play_ok) begin
                played_card_reg <= hand_reg[i_play_idx];
                count_reg       <= count_reg - 1'b1;
            end else if (capture) begin
                count_reg <= count_reg + 1'b1;
            end
            if ((state_reg == S_RECV) && i_drawn && full) begin
                overflow_reg <= 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (!i_play && (i_req_draw != 3'b000)) begin
                        need_reg <= i_req_draw[2] ? 3'd4 : (i_req_draw[1] ? 3'd2 : 3'd1);
                    end
                end
                S_REQ: begin
                    if (i_deck_done) timer_reg <= '0;
                end
                S_RECV: begin
                    // Discarded cards still count against the outstanding request.
                    if (i_drawn) begin
                        need_reg  <= need_reg - 3'd1;
                        timer_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sel_card     = ({1'b0, i_sel_idx} < count_reg) ? hand_reg[i_sel_idx] : 6'h00;
    assign o_count        = count_reg;
    assign o_played_card  = played_card_reg;
    assign o_played_valid = played_valid_reg;
    assign o_err          = err_reg;
    assign o_overflow     = overflow_reg;

endmodule

// File: tb/tb_hand_buffer.sv
// Directed bench for hand_buffer: a vector table for draw/play/view traffic, then
// hand-written sequences for deck stalls, timeout, overflow and reset mid-transfer.
module tb_hand_buffer;

    localparam int MAX_CARDS = 32;
    localparam int IDX_W     = 5;
    localparam int TIMEOUT   = 255;

    logic             i_clk;
    logic             i_rst_n;
    logic [2:0]       i_req_draw;
    logic             i_play;
    logic [IDX_W-1:0] i_play_idx;
    logic [IDX_W-1:0] i_sel_idx;
    logic             i_deck_done;
    logic             i_drawn;
    logic [5:0]       i_card;
    logic [2:0]       o_draw;
    logic [5:0]       o_sel_card;
    logic [IDX_W:0]   o_count;
    logic             o_busy;
    logic [5:0]       o_played_card;
    logic             o_played_valid;
    logic             o_err;
    logic             o_overflow;

    hand_buffer #(.MAX_CARDS(MAX_CARDS), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_draw(i_req_draw), .i_play(i_play),
        .i_play_idx(i_play_idx), .i_sel_idx(i_sel_idx), .i_deck_done(i_deck_done),
        .i_drawn(i_drawn), .i_card(i_card), .o_draw(o_draw), .o_sel_card(o_sel_card),
        .o_count(o_count), .o_busy(o_busy), .o_played_card(o_played_card),
        .o_played_valid(o_played_valid), .o_err(o_err), .o_overflow(o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] req;
        logic       done;
        logic       drawn;
        logic [5:0] card;
        logic       play;
        logic [4:0] pidx;
        logic [4:0] sel;
        logic [2:0] e_draw;
        int         e_count;
        logic       e_busy;
        logic       e_err;
        logic       e_pv;
        logic [5:0] e_pc;
        logic [5:0] e_sel;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [2:0] req, input logic done, input logic drawn,
                                input logic [5:0] card, input logic play, input logic [4:0] pidx,
                                input logic [4:0] sel, input logic [2:0] e_draw, input int e_count,
                                input logic e_busy, input logic e_err, input logic e_pv,
                                input logic [5:0] e_pc, input logic [5:0] e_sel);
        vec_t v;
        v.req = req; v.done = done; v.drawn = drawn; v.card = card; v.play = play;
        v.pidx = pidx; v.sel = sel; v.e_draw = e_draw; v.e_count = e_count; v.e_busy = e_busy;
        v.e_err = e_err; v.e_pv = e_pv; v.e_pc = e_pc; v.e_sel = e_sel;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req_draw = 3'b000; i_play = 1'b0; i_play_idx = '0; i_sel_idx = '0;
        i_deck_done = 1'b0; i_drawn = 1'b0; i_card = '0;
    endtask

    // Request a draw with the deck ready and deliver n cards back to back.
    task automatic do_draw(input logic [2:0] code, input int n, input logic [5:0] base);
        i_req_draw = code; i_deck_done = 1'b1;
        step();
        i_req_draw = 3'b000;
        chk("do_draw_code", int'(o_draw), int'(code));
        step();
        i_deck_done = 1'b0;
        for (int i = 0; i < n; i++) begin
            i_drawn = 1'b1; i_card = base + 6'(i);
            step();
        end
        i_drawn = 1'b0;
        $display("draw code=%b n=%0d count=%0d busy=%0b", code, n, o_count, o_busy);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           req     dn dr card   pl idx sel  draw    cnt bsy err pv pc     sel
        vecs[0]  = mk(3'b001, 1, 0, 6'h00, 0, 0, 0, 3'b000, 0, 1, 0, 0, 6'h05 & 6'h00, 6'h00);
        vecs[1]  = mk(3'b000, 1, 0, 6'h00, 0, 0, 0, 3'b001, 0, 1, 0, 0, 6'h00, 6'h00);
        vecs[2]  = mk(3'b000, 0, 1, 6'h05, 0, 0, 0, 3'b000, 1, 0, 0, 0, 6'h00, 6'h05);
        vecs[3]  = mk(3'b000, 0, 0, 6'h00, 1, 0, 0, 3'b000, 0, 0, 0, 1, 6'h05, 6'h00);
        vecs[4]  = mk(3'b010, 1, 0, 6'h00, 0, 0, 0, 3'b000, 0, 1, 0, 0, 6'h05, 6'h00);
        vecs[5]  = mk(3'b000, 1, 0, 6'h00, 0, 0, 0, 3'b010, 0, 1, 0, 0, 6'h05, 6'h00);
        vecs[6]  = mk(3'b000, 0, 1, 6'h01, 0, 0, 0, 3'b000, 1, 1, 0, 0, 6'h05, 6'h01);
        vecs[7]  = mk(3'b000, 0, 1, 6'h12, 0, 0, 0, 3'b000, 2, 0, 0, 0, 6'h05, 6'h01);
        vecs[8]  = mk(3'b001, 1, 0, 6'h00, 0, 0, 0, 3'b000, 2, 1, 0, 0, 6'h05, 6'h01);
        vecs[9]  = mk(3'b000, 1, 0, 6'h00, 0, 0, 0, 3'b001, 2, 1, 0, 0, 6'h05, 6'h01);
        vecs[10] = mk(3'b000, 0, 1, 6'h23, 0, 0, 0, 3'b000, 3, 0, 0, 0, 6'h05, 6'h01);
        vecs[11] = mk(3'b000, 0, 0, 6'h00, 1, 0, 0, 3'b000, 2, 0, 0, 1, 6'h01, 6'h23);
        vecs[12] = mk(3'b000, 0, 0, 6'h00, 0, 0, 1, 3'b000, 2, 0, 0, 0, 6'h01, 6'h12);
        vecs[13] = mk(3'b000, 0, 0, 6'h00, 0, 0, 2, 3'b000, 2, 0, 0, 0, 6'h01, 6'h00);
        vecs[14] = mk(3'b001, 1, 0, 6'h00, 0, 0, 2, 3'b000, 2, 1, 0, 0, 6'h01, 6'h00);
        vecs[15] = mk(3'b000, 1, 0, 6'h00, 0, 0, 2, 3'b001, 2, 1, 0, 0, 6'h01, 6'h00);
        vecs[16] = mk(3'b000, 0, 1, 6'h34, 0, 0, 2, 3'b000, 3, 0, 0, 0, 6'h01, 6'h34);
        vecs[17] = mk(3'b001, 1, 0, 6'h00, 1, 7, 2, 3'b000, 3, 0, 1, 0, 6'h01, 6'h34);
        vecs[18] = mk(3'b000, 1, 0, 6'h00, 0, 0, 0, 3'b000, 3, 0, 0, 0, 6'h01, 6'h23);
        vecs[19] = mk(3'b000, 0, 0, 6'h00, 1, 2, 1, 3'b000, 2, 0, 0, 1, 6'h34, 6'h12);

        // Reset
        clear_inputs();
        i_rst_n = 1'b0;
        step();
        step();
        chk("rst_count", int'(o_count), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_draw", int'(o_draw), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_pv", int'(o_played_valid), 0);
        chk("rst_pc", int'(o_played_card), 0);
        chk("rst_overflow", int'(o_overflow), 0);
        chk("rst_sel", int'(o_sel_card), 0);
        i_rst_n = 1'b1;
        step();
        chk("post_rst_count", int'(o_count), 0);
        chk("post_rst_busy", int'(o_busy), 0);

        // Vector table
        for (int i = 0; i < 20; i++) begin
            i_req_draw = vecs[i].req; i_deck_done = vecs[i].done; i_drawn = vecs[i].drawn;
            i_card = vecs[i].card; i_play = vecs[i].play; i_play_idx = vecs[i].pidx;
            i_sel_idx = vecs[i].sel;
            #1;
            chk($sformatf("vec%0d_draw", i), int'(o_draw), int'(vecs[i].e_draw));
            step();
            chk($sformatf("vec%0d_count", i), int'(o_count), vecs[i].e_count);
            chk($sformatf("vec%0d_busy", i), int'(o_busy), int'(vecs[i].e_busy));
            chk($sformatf("vec%0d_err", i), int'(o_err), int'(vecs[i].e_err));
            chk($sformatf("vec%0d_pv", i), int'(o_played_valid), int'(vecs[i].e_pv));
            chk($sformatf("vec%0d_pc", i), int'(o_played_card), int'(vecs[i].e_pc));
            chk($sformatf("vec%0d_sel", i), int'(o_sel_card), int'(vecs[i].e_sel));
            $display("vec %0d count=%0d busy=%0b err=%0b pv=%0b", i, o_count, o_busy, o_err,
                     o_played_valid);
        end
        clear_inputs();
        chk("table_overflow", int'(o_overflow), 0);

        // Deck stalls for 5 cycles, then four cards arrive every third cycle
        i_req_draw = 3'b100;
        step();
        i_req_draw = 3'b000;
        chk("stall_busy", int'(o_busy), 1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall_draw%0d", k), int'(o_draw), 0);
            step();
        end
        i_deck_done = 1'b1;
        #1;
        chk("stall_draw_pulse", int'(o_draw), 4);
        step();
        i_deck_done = 1'b0;
        chk("stall_draw_after", int'(o_draw), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            step();
            i_drawn = 1'b1; i_card = 6'h10 + 6'(k);
            step();
            i_drawn = 1'b0;
        end
        i_sel_idx = 5'd5;
        #1;
        chk("stall_count", int'(o_count), 6);
        chk("stall_busy_end", int'(o_busy), 0);
        chk("stall_sel5", int'(o_sel_card), 6'h13);
        $display("stall draw count=%0d", o_count);

        // Timeout after one of two cards
        i_req_draw = 3'b010; i_deck_done = 1'b1;
        step();
        i_req_draw = 3'b000;
        step();
        i_deck_done = 1'b0;
        i_drawn = 1'b1; i_card = 6'h2A;
        step();
        i_drawn = 1'b0;
        chk("to_count_mid", int'(o_count), 7);
        begin
            int n;
            n = 0;
            while (!o_err && n < 400) begin
                step();
                n++;
            end
            chk("to_cycles", n, TIMEOUT);
        end
        chk("to_count", int'(o_count), 7);
        chk("to_busy", int'(o_busy), 0);
        step();
        chk("to_err_clear", int'(o_err), 0);
        $display("timeout count=%0d", o_count);

        // Fill to 31 cards, then draw two with one slot left
        for (int d = 0; d < 6; d++) begin
            do_draw(3'b100, 4, 6'h30);
        end
        chk("fill_count", int'(o_count), 31);
        chk("fill_overflow", int'(o_overflow), 0);
        do_draw(3'b010, 2, 6'h3E);
        i_sel_idx = 5'd31;
        #1;
        chk("ovf_count", int'(o_count), 32);
        chk("ovf_flag", int'(o_overflow), 1);
        chk("ovf_busy", int'(o_busy), 0);
        chk("ovf_sel31", int'(o_sel_card), 6'h3E);
        i_play = 1'b1; i_play_idx = 5'd0; i_sel_idx = 5'd0;
        step();
        i_play = 1'b0;
        chk("ovf_play_pv", int'(o_played_valid), 1);
        chk("ovf_play_pc", int'(o_played_card), 6'h23);
        chk("ovf_play_count", int'(o_count), 31);
        chk("ovf_play_sel0", int'(o_sel_card), 6'h3E);
        chk("ovf_sticky", int'(o_overflow), 1);
        $display("overflow count=%0d overflow=%0b", o_count, o_overflow);

        // Reset in the middle of a transfer
        i_req_draw = 3'b100; i_deck_done = 1'b1;
        step();
        i_req_draw = 3'b000;
        step();
        i_deck_done = 1'b0;
        i_drawn = 1'b1; i_card = 6'h07;
        step();
        i_drawn = 1'b0;
        chk("mid_busy", int'(o_busy), 1);
        i_rst_n = 1'b0;
        step();
        chk("mid_rst_err", int'(o_err), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_count", int'(o_count), 0);
        chk("mid_rst_overflow", int'(o_overflow), 0);
        i_rst_n = 1'b1;
        step();
        chk("mid_post_err", int'(o_err), 0);
        chk("mid_post_busy", int'(o_busy), 0);
        $display("reset mid-transfer count=%0d", o_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
